// File: rtl/sn_pkg.sv
// Shared types and constants for the stochastic-number datapath.
// The default stream length is shared with the generator stage.
package sn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } sna_state_t;

  localparam int SN_STREAM_LEN = 16;

  // Result width needed to hold every possible count of ones in one window.
  function automatic int sum_width(input int lanes, input int stream_len);
    return $clog2(lanes * stream_len + 1);
  endfunction

endpackage

// File: rtl/sn_popcount.sv
// Combinational count of set bits across the stochastic lanes.
module sn_popcount #(
  parameter int LANES = 4,
  localparam int PC_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] bits,
  output logic [PC_W-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      count = count + PC_W'(bits[i]);
    end
  end

endmodule

// File: rtl/sn_accumulator.sv
// Stochastic-to-binary converter: sums lane popcounts over a fixed window
// and presents the total on a valid/ready output.
//
// state | meaning
// IDLE  | waiting for a start pulse
// ACC   | sampling i_sn_bits, one sample per edge, STREAM_LEN samples
// DONE  | result held on o_sum with o_valid until accepted
module sn_accumulator
  import sn_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int STREAM_LEN = SN_STREAM_LEN,
  localparam int SUM_W     = sum_width(LANES, STREAM_LEN)
) (
  input  logic             i_clk_sna,
  input  logic             i_rst_sna,
  input  logic             i_start_sna,
  input  logic             i_stop_sna,
  input  logic [LANES-1:0] i_sn_bits,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [SUM_W-1:0] o_sum,
  output logic             o_busy
);

  localparam int PC_W  = $clog2(LANES + 1);
  localparam int CNT_W = $clog2(STREAM_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STREAM_LEN - 1);

  sna_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [SUM_W-1:0]  acc;
  logic [SUM_W-1:0]  acc_next;
  logic [PC_W-1:0]   pop_cnt;

  sn_popcount #(.LANES(LANES)) u_popcount (
    .bits  (i_sn_bits),
    .count (pop_cnt)
  );

  // SUM_W always exceeds PC_W and covers the full window, so no wrap is possible.
  assign acc_next = acc + SUM_W'(pop_cnt);

  always_ff @(posedge i_clk_sna) begin
    if (i_rst_sna) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start_sna) begin
            state  <= ACC;
            cnt    <= '0;
            acc    <= '0;
            o_busy <= 1'b1;
          end
        end
        ACC: begin
          if (i_stop_sna) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (cnt == LAST_CNT) begin
            state   <= DONE;
            acc     <= acc_next;
            o_sum   <= acc_next;
            o_valid <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            // Start in the handshake cycle chains the next window with no gap.
            if (i_start_sna) begin
              state  <= ACC;
              cnt    <= '0;
              acc    <= '0;
              o_busy <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
